arb_mux: RTL
============

# arb_mux

- Parametrised N-channel arbitrating multiplexer with a one-entry registered output stage and valid/ready handshakes on every input and on the output.
- Generalises the combinational 2:1 and 4:1 selectors: channel choice is made by an internal arbiter instead of an external select.
- Arbitration is either fixed-priority or round-robin.
- Sits between multiple datapath/memory requesters (e.g. instruction fetch vs. data access in the multi-cycle CPU) and a single shared consumer.

## Interface

Parameters:
- DATA_WIDTH, 16, width of each channel payload
- NUM_CH, 4, number of input channels; legal range 2..16
- SEL_WIDTH, derived localparam = $clog2(NUM_CH), width of channel index

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- mode  input  1  arbitration mode: 0 = fixed priority (ARB_MODE_FIXED), 1 = round-robin (ARB_MODE_RR)
- in_valid  input  NUM_CH  per-channel request
- in_data  input  NUM_CH*DATA_WIDTH  packed payloads; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_ready  output  NUM_CH  per-channel accept; at most one bit high in any cycle
- out_valid  output  1  output register holds a valid word
- out_ready  input  1  consumer accepts the word
- out_data  output  DATA_WIDTH  registered payload
- out_sel  output  SEL_WIDTH  index of the channel that produced out_data

## Operation

- Output register states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_accept = !out_valid | out_ready.
- grant:
  - One-hot vector computed combinationally from in_valid, mode and rr_ptr.
  - All zero when no in_valid is set.
- in_ready[i] = grant[i] & can_accept (combinational; depends on out_ready).
- Transfer on channel i when in_valid[i] & in_ready[i]. On that edge:
  - out_data <= channel i payload.
  - out_sel <= i.
  - out_valid <= 1.
- Drain without refill (out_valid & out_ready and no transfer): out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous drain and refill: the new word replaces the old one and out_valid stays 1. This gives a sustained throughput of one word per cycle.
- FULL with out_ready=0: out_data and out_sel are held stable and all in_ready are 0.
- Fixed priority: the lowest-indexed requesting channel wins.
- Round-robin:
  - The search starts at (rr_ptr+1) mod NUM_CH and wraps past NUM_CH-1 to 0.
  - The first requesting channel in that order wins.
- rr_ptr <= index of the transferred channel, on every transfer in either mode. It does not change when no transfer occurs.
- Mode change takes effect in the same cycle it is applied. rr_ptr is preserved across mode changes.
- Sources hold in_valid and in_data stable until accepted. A requester may be passed over while it waits; it is not starved in round-robin mode.

## Timing

- Reset values (asynchronous, immediate on reset_n low):
  - out_valid=0
  - out_data=0
  - out_sel=0
  - rr_ptr=NUM_CH-1, so channel 0 has first round-robin priority
  - in_ready=0 while reset_n low
- Latency: an input accepted at edge k appears on out_data/out_valid immediately after edge k, i.e. one cycle.
- Combinational paths:
  - in_valid/mode → in_ready.
  - out_ready → in_ready.
  - No combinational path from any input to out_data/out_valid.
- Reset asserted mid-transfer discards the held word. The first post-reset grant follows the reset rr_ptr.
- Round-robin worst-case wait for a continuously requesting channel: NUM_CH-1 transfers.

## Structure

- Shared header (alongside the existing opcode definitions):
  - ARB_MODE_FIXED = 1'b0
  - ARB_MODE_RR = 1'b1
- One sub-module, rr_picker:
  - Purely combinational.
  - Inputs: req[NUM_CH], ptr[SEL_WIDTH], mode.
  - Outputs: one-hot grant[NUM_CH] and grant index.
  - Implemented as a rotated priority encoder; fixed mode uses rotation 0.
- Top level holds the output register, rr_ptr and the handshake logic.

## Test plan

- Reset with NUM_CH=4, DATA_WIDTH=16:
  - Hold reset_n=0 with all in_valid=1. Expect out_valid=0, out_data=0, in_ready=0.
  - Release reset with mode=RR. Channel 0 (0x1111) is granted first and appears on out_data one cycle later with out_sel=0.
- Fixed priority: in_valid=4'b1010, out_ready=1, mode=0. Channel 1 wins every cycle, channel 3 never receives in_ready.
- Round-robin fairness: all four channels valid with payloads 0xA000+i, out_ready=1, mode=1. Output sequence is out_sel 0,1,2,3,0 on consecutive cycles with out_valid continuously 1.
- Backpressure:
  - Fill the register with 0x1234, then hold out_ready=0 for 5 cycles. out_data stays 0x1234 and in_ready=0 throughout.
  - Raise out_ready. The next word is accepted in the same cycle as the drain.
- Wrap and idle:
  - rr_ptr=3 with only channel 2 requesting: channel 2 is granted (wrap via 0,1).
  - Then no requests with out_ready=1: out_valid falls to 0 after one cycle and out_data holds its last value.
- Reset mid-operation: assert reset_n=0 while FULL and backpressured. out_valid drops immediately, and after release the round-robin order restarts at channel 0.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// -----------------------------------------------------------------------------
// arb_mux_pkg
// Shared definitions for the arbitrating multiplexer:
//   - arbitration mode encodings (ARB_MODE_FIXED / ARB_MODE_RR)
//   - default parameter values for DATA_WIDTH / NUM_CH
//   - wrap_add: modular increment used by the rotated priority encoder
// -----------------------------------------------------------------------------
package arb_mux_pkg;

  // Arbitration mode encodings driven on the 'mode' port
  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;

  // Default datapath geometry; legal channel count is 2..16
  localparam int unsigned ARB_DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned ARB_DEFAULT_NUM_CH     = 4;

  // (base + off) mod n, for base and off both already in [0, n)
  function automatic int unsigned wrap_add(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    int unsigned sum;
    sum = base + off;
    if (sum >= n) begin
      sum = sum - n;
    end
    return sum;
  endfunction

endpackage : arb_mux_pkg

// File: rtl/arb_mux_rr_picker.sv
// -----------------------------------------------------------------------------
// arb_mux_rr_picker
// Purely combinational rotated priority encoder (the rr_picker of arb_mux).
// The search starts at (ptr+1) mod NUM_CH in round-robin mode and at
// channel 0 in fixed mode, wrapping past NUM_CH-1; the first requester wins.
// Ports:
//   req       in   NUM_CH     per-channel request
//   ptr       in   SEL_WIDTH  index of the most recently served channel
//   mode      in   1          ARB_MODE_FIXED / ARB_MODE_RR
//   grant     out  NUM_CH     one-hot grant, all zero when req is zero
//   grant_idx out  SEL_WIDTH  binary index of the granted channel
// -----------------------------------------------------------------------------
module arb_mux_rr_picker
  import arb_mux_pkg::*;
#(
  parameter int unsigned NUM_CH    = ARB_DEFAULT_NUM_CH,
  parameter int unsigned SEL_WIDTH = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]    req,
  input  logic [SEL_WIDTH-1:0] ptr,
  input  logic                 mode,
  output logic [NUM_CH-1:0]    grant,
  output logic [SEL_WIDTH-1:0] grant_idx
);

  int unsigned base;
  int unsigned pos;
  logic        found;

  // Rotated search: fixed priority is simply a rotation of zero
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    base      = (mode == ARB_MODE_RR) ? wrap_add(32'(ptr), 32'd1, NUM_CH) : 32'd0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      pos = wrap_add(base, k, NUM_CH);
      if (!found && req[SEL_WIDTH'(pos)]) begin
        found                    = 1'b1;
        grant[SEL_WIDTH'(pos)]   = 1'b1;
        grant_idx                = SEL_WIDTH'(pos);
      end
    end
  end

endmodule : arb_mux_rr_picker

// File: rtl/arb_mux.sv
// -----------------------------------------------------------------------------
// arb_mux
// N-channel arbitrating multiplexer with a one-entry registered output stage.
// An internal arbiter (fixed priority or round-robin) picks one requesting
// channel; its payload is captured into the output register when the register
// is empty or being drained in the same cycle.
// Ports:
//   clk        in   1                  rising-edge clock
//   reset_n    in   1                  asynchronous active-low reset
//   mode       in   1                  0 = fixed priority, 1 = round-robin
//   in_valid   in   NUM_CH             per-channel request
//   in_data    in   NUM_CH*DATA_WIDTH  packed payloads, channel i at [i*DW +: DW]
//   in_ready   out  NUM_CH             per-channel accept (combinational, <=1 hot)
//   out_valid  out  1                  output register holds a word
//   out_ready  in   1                  consumer accepts the word
//   out_data   out  DATA_WIDTH         registered payload
//   out_sel    out  SEL_WIDTH          channel that produced out_data
// -----------------------------------------------------------------------------
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ARB_DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_CH     = ARB_DEFAULT_NUM_CH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         mode,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(NUM_CH)-1:0]    out_sel
);

  localparam int unsigned SEL_WIDTH = $clog2(NUM_CH);

  logic [NUM_CH-1:0]     grant;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic [SEL_WIDTH-1:0]  rr_ptr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  can_accept;
  logic                  xfer;

  // Arbiter: one-hot grant over the current requests
  arb_mux_rr_picker #(
    .NUM_CH    (NUM_CH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_picker (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .mode      (mode),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Register can take a word when empty or when it is drained this cycle.
  // reset_n gates in_ready so no channel sees an accept while reset is held.
  always_comb begin
    can_accept = !out_valid || out_ready;
    in_ready   = grant & {NUM_CH{can_accept && reset_n}};
    xfer       = |(in_valid & in_ready);
  end

  // AND-OR payload mux driven by the one-hot grant
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output register and round-robin pointer.
  // rr_ptr resets to NUM_CH-1 so channel 0 is first in round-robin order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= SEL_WIDTH'(NUM_CH - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_idx;
      rr_ptr    <= grant_idx;
    end else if (out_ready) begin
      // Drain without refill: payload and index hold their last values
      out_valid <= 1'b0;
    end
  end

endmodule : arb_mux
